// File: rtl/spi_cfg_pkg.sv
// rtl/spi_cfg_pkg.sv - shared types and constants for the configuration SPI master
// Contents: FSM state enum, frame format constants, receiver register map,
// FRAME_CYC latency helper and frame packing helper.
package spi_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOW,
    ST_HIGH,
    ST_HOLD,
    ST_GAP
  } state_t;

  localparam int   FRAME_BITS = 16;
  localparam logic WRITE_BIT  = 1'b1;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'd0;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'd1;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'd2;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'd3;
  localparam logic [6:0] ADDR_PWM_DUTY  = 7'd4;

  // Number of clk cycles from the cycle in which the FSM launches a frame
  // (request acceptance without the queue) up to and including the cycle in
  // which done is high. SETUP + 16 HIGH + 15 LOW + HOLD phases of div_half
  // cycles each, then gap_cyc GAP cycles, then the done cycle itself.
  function automatic int FRAME_CYC(input int div_half, input int gap_cyc);
    return (1 + 2 * FRAME_BITS - 1 + 1) * div_half + gap_cyc + 1;
  endfunction

  function automatic logic [15:0] make_frame(input logic [6:0] addr, input logic [7:0] data);
    return {WRITE_BIT, addr, data};
  endfunction

endpackage

// File: rtl/spi_cfg_fifo.sv
// rtl/spi_cfg_fifo.sv - synchronous request queue with full/empty flags
// Ports: clk, rst_n (async active-low); push/push_data write side;
// pop/pop_data read side (pop_data shows the head entry, first-word
// fall-through); full, empty status. Pushes while full and pops while empty
// are ignored. DEPTH must be a power of two so the pointers wrap naturally.
module spi_cfg_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spi_cfg_master.sv
// rtl/spi_cfg_master.sv - SPI mode-0 write-only master for the config peripheral
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_addr/req_data
// request handshake; busy (FSM not idle); done (one-cycle pulse at end of GAP);
// spi_ncs/spi_sclk/spi_copi registered SPI outputs.
// Frame: {1'b1, addr[6:0], data[7:0]}, MSB first, 16 SCLK rising edges.
// Build option CMD_FIFO_EN: FIFO_DEPTH-entry request queue, frames chained.
module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter int DIV_HALF   = 4,
  parameter int GAP_CYC    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       spi_ncs,
  output logic       spi_sclk,
  output logic       spi_copi
);

  if (DIV_HALF < 3 || DIV_HALF > 255 || GAP_CYC < 4 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("spi_cfg_master: illegal parameter value");
  end

  state_t      state_q, state_d;
  logic [15:0] shreg_q, shreg_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] cyc_cnt_q, cyc_cnt_d;
  logic        ncs_q, ncs_d;
  logic        sclk_q, sclk_d;
  logic        copi_q, copi_d;
  logic        done_q, done_d;

  logic        launch_valid;
  logic [14:0] launch_data;
  logic        half_end;
  logic        gap_end;
  logic        start_ok;
  logic        do_start;

`ifdef CMD_FIFO_EN
  // Queued requests may be launched straight out of GAP, so frames run
  // back-to-back while still keeping the full GAP between them.
  localparam bit CHAIN = 1'b1;

  logic fifo_full;
  logic fifo_empty;

  spi_cfg_fifo #(
    .WIDTH (15),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_valid),
    .push_data ({req_addr, req_data}),
    .pop       (do_start),
    .pop_data  (launch_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign req_ready    = !fifo_full;
  assign launch_valid = !fifo_empty;
`else
  localparam bit CHAIN = 1'b0;

  assign req_ready    = (state_q == ST_IDLE);
  assign launch_valid = req_valid;
  assign launch_data  = {req_addr, req_data};
`endif

  assign half_end = (cyc_cnt_q == 16'(DIV_HALF - 1));
  assign gap_end  = (cyc_cnt_q == 16'(GAP_CYC - 1));
  assign start_ok = (state_q == ST_IDLE) || (CHAIN && state_q == ST_GAP && gap_end);
  assign do_start = start_ok && launch_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      cyc_cnt_q <= '0;
      ncs_q     <= 1'b1;
      sclk_q    <= 1'b0;
      copi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      ncs_q     <= ncs_d;
      sclk_q    <= sclk_d;
      copi_q    <= copi_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    ncs_d     = ncs_q;
    sclk_d    = sclk_q;
    copi_d    = copi_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cyc_cnt_d = '0;
      end
      ST_SETUP, ST_LOW: begin
        if (half_end) begin
          cyc_cnt_d = '0;
          sclk_d    = 1'b1;
          state_d   = ST_HIGH;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (half_end) begin
          cyc_cnt_d = '0;
          sclk_d    = 1'b0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 5'(FRAME_BITS - 1)) begin
            state_d = ST_HOLD;
          end else begin
            // Data changes on the falling edge, a full half-period before
            // the next rising edge.
            shreg_d = shreg_q << 1;
            copi_d  = shreg_q[14];
            state_d = ST_LOW;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (half_end) begin
          cyc_cnt_d = '0;
          ncs_d     = 1'b1;
          copi_d    = 1'b0;
          state_d   = ST_GAP;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_end) begin
          cyc_cnt_d = '0;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Launch overrides the per-state defaults: chip select drops and the
    // first (write) bit is presented together, one cycle after acceptance.
    if (do_start) begin
      shreg_d   = {WRITE_BIT, launch_data};
      copi_d    = WRITE_BIT;
      ncs_d     = 1'b0;
      sclk_d    = 1'b0;
      bit_cnt_d = '0;
      cyc_cnt_d = '0;
      state_d   = ST_SETUP;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign spi_ncs  = ncs_q;
  assign spi_sclk = sclk_q;
  assign spi_copi = copi_q;

endmodule

// File: tb/tb_spi_cfg_master.sv
// tb/tb_spi_cfg_master.sv - self-checking bench for spi_cfg_master with a receiver model
module tb_spi_cfg_master;
  import spi_cfg_pkg::*;

`ifdef CMD_FIFO_EN
  localparam int D      = 3;
  localparam int LAUNCH = 1;
`else
  localparam int D      = 4;
  localparam int LAUNCH = 0;
`endif
  localparam int G = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       busy;
  logic       done;
  logic       spi_ncs;
  logic       spi_sclk;
  logic       spi_copi;

  int checks = 0;
  int failures = 0;

  spi_cfg_master #(
    .DIV_HALF   (D),
    .GAP_CYC    (G),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .busy      (busy),
    .done      (done),
    .spi_ncs   (spi_ncs),
    .spi_sclk  (spi_sclk),
    .spi_copi  (spi_copi)
  );

  always #5 clk = ~clk;

  // Receiver model: the peripheral keeps its registers across master reset
  // and commits only complete 16-bit write frames to addresses 0..4.
  logic [7:0]  regs [5] = '{default: 8'h00};
  logic [15:0] frames [$];
  logic [15:0] rx;
  int          bits, phase, gap_cnt, stable, total_rises, done_cnt;
  logic        prev_ncs = 1'b1, prev_sclk = 1'b0, prev_copi = 1'b0;

  initial begin
    rx = '0; bits = 0; phase = 0; gap_cnt = 1000; stable = 0; total_rises = 0; done_cnt = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      bits = 0; phase = 0; gap_cnt = 1000; stable = 0; rx = '0;
      prev_ncs = 1'b1; prev_sclk = 1'b0; prev_copi = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (prev_ncs && !spi_ncs) begin
        checks++;
        if (gap_cnt < G) begin
          failures++;
          $display("FAIL gap_len got=%0d required>=%0d", gap_cnt, G);
        end
        bits = 0; rx = '0;
      end
      if (!spi_ncs && prev_ncs) begin
        phase = 1;
      end else if (!spi_ncs && spi_sclk != prev_sclk) begin
        checks++;
        if (phase != D) begin
          failures++;
          $display("FAIL phase_len sclk=%b got=%0d required=%0d", prev_sclk, phase, D);
        end
        if (spi_sclk) begin
          checks++;
          if (stable < D || spi_copi !== prev_copi) begin
            failures++;
            $display("FAIL copi_setup got=%0d required>=%0d", stable, D);
          end
          rx = {rx[14:0], spi_copi};
          bits++;
          total_rises++;
        end
        phase = 1;
      end else begin
        phase++;
      end
      if (!prev_ncs && spi_ncs) begin
        if (bits == 16) begin
          checks++;
          if (phase - 1 != D) begin
            failures++;
            $display("FAIL hold_len got=%0d required=%0d", phase - 1, D);
          end
          frames.push_back(rx);
          if (rx[15] && rx[14:8] < 7'd5) regs[rx[14:8]] = rx[7:0];
        end
        gap_cnt = 1;
      end else if (spi_ncs) begin
        gap_cnt++;
      end
      if (spi_copi !== prev_copi) stable = 1;
      else stable++;
      prev_ncs = spi_ncs; prev_sclk = spi_sclk; prev_copi = spi_copi;
    end
  end

  task automatic send(input logic [6:0] a, input logic [7:0] d);
    int n = 0;
    req_addr = a; req_data = d; req_valid = 1'b1;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_ready) begin
      failures++;
      $display("FAIL send_timeout ready=%b required=1", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_frames(input int base, input int n);
    int k = 0;
    while (done_cnt - base < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (done_cnt - base != n) begin
      failures++;
      $display("FAIL wait_done got=%0d required=%0d", done_cnt - base, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (spi_ncs !== 1'b1)   begin failures++; $display("FAIL rst_ncs got=%b required=1", spi_ncs); end
    if (spi_sclk !== 1'b0)  begin failures++; $display("FAIL rst_sclk got=%b required=0", spi_sclk); end
    if (spi_copi !== 1'b0)  begin failures++; $display("FAIL rst_copi got=%b required=0", spi_copi); end
    if (busy !== 1'b0)      begin failures++; $display("FAIL rst_busy got=%b required=0", busy); end
    if (done !== 1'b0)      begin failures++; $display("FAIL rst_done got=%b required=0", done); end
    if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b required=1", req_ready); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (spi_ncs !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_rst_idle ncs=%b busy=%b required ncs=1 busy=0", spi_ncs, busy);
    end
  endtask

  task automatic test_single();
    int k = 0, first_rise = 0, nf, r0;
    nf = frames.size(); r0 = total_rises;
    send(ADDR_PWM_DUTY, 8'h80);
    while (!done && k < 1000) begin
      @(negedge clk);
      k++;
      if (spi_sclk && first_rise == 0) first_rise = k;
      if (k == 1) begin
        checks++;
        if (busy !== 1'b1 || (LAUNCH == 0 && (spi_ncs !== 1'b0 || spi_copi !== 1'b1))) begin
          failures++;
          $display("FAIL first_cycle busy=%b ncs=%b copi=%b required 1,0,1", busy, spi_ncs, spi_copi);
        end
      end
    end
    checks += 2;
    if (first_rise != D + 1 + LAUNCH) begin
      failures++; $display("FAIL first_rise got=%0d required=%0d", first_rise, D + 1 + LAUNCH);
    end
    if (k != 33 * D + G + 1 + LAUNCH) begin
      failures++; $display("FAIL latency got=%0d required=%0d", k, 33 * D + G + 1 + LAUNCH);
    end
    @(negedge clk);
    checks += 4;
    if (done !== 1'b0) begin failures++; $display("FAIL done_pulse got=%b required=0", done); end
    if (total_rises - r0 != 16) begin failures++; $display("FAIL rise_count got=%0d required=16", total_rises - r0); end
    if (frames.size() != nf + 1 || frames[frames.size()-1] !== 16'h8480) begin
      failures++; $display("FAIL frame_duty got=%h required=8480", frames[frames.size()-1]);
    end
    if (regs[4] !== 8'h80) begin failures++; $display("FAIL reg_duty got=%h required=80", regs[4]); end
  endtask

  task automatic test_back_to_back();
    int d0, nf;
    d0 = done_cnt; nf = frames.size();
    send(ADDR_EN_OUT_LO, 8'hA5);
    req_addr = ADDR_EN_OUT_HI; req_data = 8'h5A; req_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== (LAUNCH ? 1'b1 : 1'b0)) begin
      failures++; $display("FAIL ready_busy got=%b required=%b", req_ready, LAUNCH ? 1'b1 : 1'b0);
    end
    send(ADDR_EN_OUT_HI, 8'h5A);
    wait_frames(d0, 2);
    repeat (3) @(negedge clk);
    checks += 4;
    if (done_cnt - d0 != 2) begin failures++; $display("FAIL done_count got=%0d required=2", done_cnt - d0); end
    if (frames.size() != nf + 2 || frames[nf] !== 16'h80A5 || frames[nf+1] !== 16'h815A) begin
      failures++; $display("FAIL b2b_order size=%0d required=%0d", frames.size(), nf + 2);
    end
    if (regs[0] !== 8'hA5) begin failures++; $display("FAIL reg_out_lo got=%h required=a5", regs[0]); end
    if (regs[1] !== 8'h5A) begin failures++; $display("FAIL reg_out_hi got=%h required=5a", regs[1]); end
  endtask

  task automatic test_unmapped();
    logic [7:0] snap [5];
    int d0;
    for (int i = 0; i < 5; i++) snap[i] = regs[i];
    d0 = done_cnt;
    send(7'd7, 8'hFF);
    wait_frames(d0, 1);
    @(negedge clk);
    checks++;
    if (frames[frames.size()-1] !== 16'h87FF) begin
      failures++; $display("FAIL frame_unmapped got=%h required=87ff", frames[frames.size()-1]);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (regs[i] !== snap[i]) begin
        failures++; $display("FAIL reg_untouched idx=%0d got=%h required=%h", i, regs[i], snap[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int r0, nf, k = 0, d0;
    logic [7:0] r2;
    r0 = total_rises; nf = frames.size(); r2 = regs[2];
    send(ADDR_EN_PWM_LO, 8'h3C);
    while (total_rises - r0 < 9 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (total_rises - r0 != 9) begin
      failures++; $display("FAIL ninth_rise got=%0d required=9", total_rises - r0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (spi_ncs !== 1'b1)  begin failures++; $display("FAIL async_ncs got=%b required=1", spi_ncs); end
    if (spi_sclk !== 1'b0) begin failures++; $display("FAIL async_sclk got=%b required=0", spi_sclk); end
    if (spi_copi !== 1'b0) begin failures++; $display("FAIL async_copi got=%b required=0", spi_copi); end
    if (busy !== 1'b0)     begin failures++; $display("FAIL async_busy got=%b required=0", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks += 2;
    if (regs[2] !== r2) begin failures++; $display("FAIL partial_commit got=%h required=%h", regs[2], r2); end
    if (frames.size() != nf) begin failures++; $display("FAIL partial_frame got=%0d required=%0d", frames.size(), nf); end
    d0 = done_cnt;
    send(ADDR_EN_PWM_LO, 8'h3C);
    wait_frames(d0, 1);
    @(negedge clk);
    checks++;
    if (regs[2] !== 8'h3C) begin failures++; $display("FAIL rewrite_pwm_lo got=%h required=3c", regs[2]); end
  endtask

`ifdef CMD_FIFO_EN
  task automatic test_fifo();
    int d0, nf;
    logic [15:0] exp_f [5];
    exp_f[0] = 16'h8010; exp_f[1] = 16'h8111; exp_f[2] = 16'h8212;
    exp_f[3] = 16'h8313; exp_f[4] = 16'h8414;
    d0 = done_cnt; nf = frames.size();
    for (int i = 0; i < 5; i++) begin
      req_addr = 7'(i); req_data = 8'(8'h10 + i); req_valid = 1'b1;
      checks++;
      if (req_ready !== 1'b1) begin failures++; $display("FAIL fifo_push_ready idx=%0d got=0 required=1", i); end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL fifo_full_ready got=%b required=0", req_ready); end
    wait_frames(d0, 5);
    @(negedge clk);
    checks++;
    if (frames.size() != nf + 5) begin failures++; $display("FAIL fifo_frames got=%0d required=%0d", frames.size() - nf, 5); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (frames.size() == nf + 5 && frames[nf+i] !== exp_f[i]) begin
        failures++; $display("FAIL fifo_order idx=%0d got=%h required=%h", i, frames[nf+i], exp_f[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_unmapped();
    test_reset_midframe();
`ifdef CMD_FIFO_EN
    test_fifo();
`endif
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
